// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, FSM states, helpers.
package sdram_pkg;

   // {CS_n, RAS_n, CAS_n, WE_n}
   typedef logic [3:0] cmd_t;

   localparam cmd_t CMD_NOP       = 4'b0111;
   localparam cmd_t CMD_PRECHARGE = 4'b0010;
   localparam cmd_t CMD_AREF      = 4'b0001;

   // Auto-refresh sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRE      = 3'd1,
      ST_WAIT_RP  = 3'd2,
      ST_AREF     = 3'd3,
      ST_WAIT_RFC = 3'd4,
      ST_DONE     = 3'd5
   } aref_state_t;

   // Smaller of two 4-bit unsigned values
   function automatic logic [3:0] min_u4(input logic [3:0] a, input logic [3:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_aref_ctrl_if.sv
// Refresh arbiter handshake plus SDRAM command/address bus of the refresh block.
//
// Handshake: req_aref is a level meaning "refreshes are owed and the block is
// idle". The arbiter answers with en_aref, which it holds high until it sees
// the one-cycle end_aref pulse. A grant is taken only on a cycle where both
// req_aref and en_aref are high; en_aref at any other time is ignored, and
// once taken the sequence runs to completion regardless of en_aref.
interface sdram_aref_ctrl_if
   import sdram_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int BANK_W = 2
) ();

   logic              en_aref;
   logic              req_aref;
   logic              urgent_aref;
   logic              end_aref;
   cmd_t              aref_cmd;
   logic [ADDR_W-1:0] sdram_addr;
   logic [BANK_W-1:0] sdram_bank;

   // Refresh block side
   modport master (
      input  en_aref,
      output req_aref, urgent_aref, end_aref,
      output aref_cmd, sdram_addr, sdram_bank
   );

   // Arbiter / command mux side
   modport slave (
      output en_aref,
      input  req_aref, urgent_aref, end_aref,
      input  aref_cmd, sdram_addr, sdram_bank
   );

endinterface

// File: rtl/sdram_aref_tick.sv
// Refresh interval timer: counts enabled cycles and pulses tick on the wrap.
module sdram_aref_tick #(
   parameter int CLK_PER_INTERVAL = 750
) (
   input  logic s_clk,
   input  logic s_rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (CLK_PER_INTERVAL > 1) ? $clog2(CLK_PER_INTERVAL) : 1;

   logic [CNT_W-1:0] cnt;

   // Tick is high for the single cycle the counter sits on its last value
   always_comb begin
      tick = en && (cnt == CNT_W'(CLK_PER_INTERVAL - 1));
   end

   // Counter advances only while enabled and holds its value otherwise
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: tracks owed refreshes and, when granted,
// issues PRECHARGE-ALL (optional) followed by a burst of AREF commands.
module sdram_aref_ctrl
   import sdram_pkg::*;
#(
   parameter int CLK_PER_INTERVAL = 750,
   parameter int T_RP             = 2,
   parameter int T_RFC            = 7,
   parameter int BURST_MAX        = 4,
   parameter int MAX_PEND         = 8,
   parameter int URGENT_TH        = 6,
   parameter int PRECH_EN         = 1,
   parameter int ADDR_W           = 12,
   parameter int BANK_W           = 2
) (
   input  logic               s_clk,
   input  logic               s_rst,
   input  logic               flag_init_end,
   sdram_aref_ctrl_if.master  bus,
   output logic [3:0]         pend_cnt,
   output logic               busy,
   output logic               ovf_err,
   output aref_state_t        aref_state
);

   // Wait counter only needs to reach the longer of the two NOP windows.
   // Both windows are assumed to be at least one cycle long.
   localparam int WAIT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
   localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   aref_state_t       state;
   aref_state_t       state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [3:0]        burst_n;
   logic [3:0]        aref_done;
   logic              tick;
   logic              grant;

   cmd_t              cmd_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic              end_nxt;
   logic              busy_nxt;
   logic              req_nxt;
   logic              urgent_nxt;
   logic [4:0]        pend_sum;
   logic [3:0]        pend_nxt;
   logic              ovf_nxt;

   sdram_aref_tick #(
      .CLK_PER_INTERVAL (CLK_PER_INTERVAL)
   ) u_tick (
      .s_clk (s_clk),
      .s_rst (s_rst),
      .en    (flag_init_end),
      .tick  (tick)
   );

   // Debug view of the sequencer state
   always_comb begin
      aref_state = state;
   end

   // A grant is only accepted from IDLE with refreshes owed (req_aref high)
   always_comb begin
      grant = (state == ST_IDLE) && bus.en_aref && (pend_cnt != 4'd0);
   end

   // Next state and the command/address that the next state drives
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (grant) begin
               state_nxt = (PRECH_EN != 0) ? ST_PRE : ST_AREF;
            end
         end
         ST_PRE: begin
            state_nxt = ST_WAIT_RP;
         end
         ST_WAIT_RP: begin
            if (wait_cnt == WAIT_W'(T_RP - 1)) begin
               state_nxt = ST_AREF;
            end
         end
         ST_AREF: begin
            state_nxt = ST_WAIT_RFC;
         end
         ST_WAIT_RFC: begin
            if (wait_cnt == WAIT_W'(T_RFC - 1)) begin
               state_nxt = (aref_done < burst_n) ? ST_AREF : ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      cmd_nxt  = CMD_NOP;
      addr_nxt = '0;
      case (state_nxt)
         ST_PRE: begin
            cmd_nxt      = CMD_PRECHARGE;
            addr_nxt[10] = 1'b1;   // A10 high selects all banks
         end
         ST_AREF: begin
            cmd_nxt = CMD_AREF;
         end
         default: begin
            cmd_nxt = CMD_NOP;
         end
      endcase
      end_nxt  = (state_nxt == ST_DONE);
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // Owed-refresh bookkeeping: tick adds one, DONE retires the burst
   always_comb begin
      pend_sum = {1'b0, pend_cnt} + {4'd0, tick};
      if (state == ST_DONE) begin
         pend_sum = pend_sum - {1'b0, burst_n};
      end
      if (pend_sum > 5'(MAX_PEND)) begin
         pend_nxt = 4'(MAX_PEND);
      end else begin
         pend_nxt = pend_sum[3:0];
      end
      ovf_nxt    = ovf_err | (tick & (pend_cnt == 4'(MAX_PEND)));
      req_nxt    = (state_nxt == ST_IDLE) && (pend_nxt != 4'd0);
      urgent_nxt = (pend_nxt >= 4'(URGENT_TH));
   end

   // State register with burst size latch, issued-AREF count and wait timer
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         burst_n   <= 4'd0;
         aref_done <= 4'd0;
      end else begin
         state <= state_nxt;
         if ((state_nxt != state) || (state == ST_IDLE)) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (grant) begin
            burst_n   <= min_u4(pend_cnt, 4'(BURST_MAX));
            aref_done <= 4'd0;
         end else if (state == ST_AREF) begin
            aref_done <= aref_done + 4'd1;
         end
      end
   end

   // Registered outputs, so every output changes together with the state
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         bus.aref_cmd    <= CMD_NOP;
         bus.sdram_addr  <= '0;
         bus.sdram_bank  <= '0;
         bus.req_aref    <= 1'b0;
         bus.urgent_aref <= 1'b0;
         bus.end_aref    <= 1'b0;
         busy            <= 1'b0;
         pend_cnt        <= 4'd0;
         ovf_err         <= 1'b0;
      end else begin
         bus.aref_cmd    <= cmd_nxt;
         bus.sdram_addr  <= addr_nxt;
         bus.sdram_bank  <= '0;   // all-bank precharge needs no bank select
         bus.req_aref    <= req_nxt;
         bus.urgent_aref <= urgent_nxt;
         bus.end_aref    <= end_nxt;
         busy            <= busy_nxt;
         pend_cnt        <= pend_nxt;
         ovf_err         <= ovf_nxt;
      end
   end

endmodule

// File: doc/sdram_aref_ctrl.md
SDRAM_AREF_CTRL -- requirements
Module: sdram_aref_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - CLK_PER_INTERVAL, 750: s_clk cycles per refresh interval.
  - T_RP, 2: NOP cycles after PRECHARGE-ALL.
  - T_RFC, 7: NOP cycles after each AREF.
  - BURST_MAX, 4: maximum AREF commands per grant.
  - MAX_PEND, 8: pending-refresh saturation limit.
  - URGENT_TH, 6: pending level that raises urgent.
  - PRECH_EN, 1: issue PRECHARGE-ALL before AREF.
  - ADDR_W, 12: address width, at least 11.
  - BANK_W, 2: bank width.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - s_clk, in, 1: the block's only clock.
  - s_rst, in, 1: synchronous, active-high reset.
  - flag_init_end, in, 1: SDRAM initialisation complete (level).
  - en_aref, in, 1: arbiter grant, held high until end_aref.
  - req_aref, out, 1: refresh request.
  - urgent_aref, out, 1: pending count >= URGENT_TH.
  - end_aref, out, 1: one-cycle completion pulse.
  - aref_cmd, out, 4: {CS_n,RAS_n,CAS_n,WE_n}.
  - sdram_addr, out, ADDR_W: SDRAM address bus.
  - sdram_bank, out, BANK_W: SDRAM bank select.
  - pend_cnt, out, 4: number of owed refreshes.
  - busy, out, 1: state not IDLE.
  - ovf_err, out, 1: sticky pending-overflow flag.

Function
REQ-003 Command codes SHALL be: NOP = 4'b0111, PRECHARGE = 4'b0010, AREF = 4'b0001.
REQ-004 The interval counter SHALL count only while flag_init_end=1, wrap at CLK_PER_INTERVAL-1, and emit a one-cycle tick on the wrap cycle.
REQ-005 On each tick pend_cnt SHALL increment by 1, saturating at MAX_PEND; a tick arriving while pend_cnt=MAX_PEND SHALL set ovf_err.
REQ-006 req_aref SHALL be 1 when state=IDLE and pend_cnt>0, and 0 otherwise.
REQ-007 The FSM SHALL have the states IDLE, PRE, WAIT_RP, AREF, WAIT_RFC and DONE.
REQ-008 In IDLE, en_aref=1 with req_aref=1 SHALL latch n = min(pend_cnt, BURST_MAX) and move to PRE if PRECH_EN=1, else to AREF.
REQ-009 PRE SHALL last 1 cycle with aref_cmd=PRECHARGE and sdram_addr[10]=1, then move to WAIT_RP.
REQ-010 WAIT_RP SHALL last T_RP cycles with NOP, then move to AREF.
REQ-011 AREF SHALL last 1 cycle with aref_cmd=AREF, then move to WAIT_RFC.
REQ-012 WAIT_RFC SHALL last T_RFC cycles with NOP; it SHALL then return to AREF while issued AREFs < n, else move to DONE.
REQ-013 DONE SHALL last 1 cycle, assert end_aref, decrement pend_cnt by n, then return to IDLE.
REQ-014 All outputs SHALL be registered, and the first command SHALL appear on the cycle after the grant is sampled.
REQ-015 If a tick coincides with the DONE decrement, pend_cnt SHALL become pend_cnt - n + 1, saturating at MAX_PEND.
REQ-016 en_aref deasserting mid-sequence SHALL be ignored; the sequence completes.
REQ-017 en_aref=1 while req_aref=0 SHALL have no effect.
REQ-018 sdram_addr SHALL be 0 and sdram_bank SHALL be 0 in every state except PRE.
REQ-019 flag_init_end falling SHALL freeze the interval counter but SHALL NOT abort a sequence in progress.

Reset
REQ-020 s_rst=1 SHALL, on the next edge and from any state including mid-sequence, force:
  - state=IDLE, aref_cmd=NOP;
  - sdram_addr=0, sdram_bank=0;
  - req_aref=0, urgent_aref=0, end_aref=0, busy=0;
  - pend_cnt=0, ovf_err=0;
  - interval counter=0.
REQ-021 ovf_err SHALL be cleared only by reset.

Structure
REQ-022 The command codes and the FSM state enumeration SHALL reside in the shared package sdram_pkg, reused by the init, read and write blocks.
REQ-023 The interval counter and tick SHALL be a sub-module sdram_aref_tick (parameter CLK_PER_INTERVAL; ports s_clk, s_rst, en, tick).

Verification (default parameters)
REQ-024 flag_init_end=1 from cycle 0, no grant -> tick at cycle 749, req_aref=1 and pend_cnt=1 at cycle 750.
REQ-025 pend_cnt=1, en_aref pulsed at cycle t -> aref_cmd = PRE at t+1, NOP at t+2..t+3, AREF at t+4, NOP at t+5..t+11; end_aref at t+12; pend_cnt=0 at t+13.
REQ-026 Grant withheld for 3 intervals (pend_cnt=3), then granted -> one PRE and 3 AREFs spaced 8 cycles apart, a single end_aref, then pend_cnt=0.
REQ-027 Grant withheld for 9 intervals -> urgent_aref=1 once pend_cnt=6, pend_cnt holds at 8, ovf_err=1 and stays 1 after a later grant.
REQ-028 Tick coincides with DONE, n=1 -> pend_cnt unchanged and req_aref reasserts on the next cycle.
REQ-029 s_rst pulsed during WAIT_RFC -> next cycle aref_cmd=NOP, busy=0, pend_cnt=0, no end_aref.
